// File: rtl/spi_master_pkg.sv
// Shared types and sizes for the SPI command master: opcode and FSM state
// encodings plus the data/frame widths used by the top and its shift register.
package spi_master_pkg;

    localparam int MEM_WIDTH = 8;
    localparam int ADDR_SIZE = 8;
    localparam int FRAME_W   = 2 + MEM_WIDTH;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        SEND,
        WAIT,
        RECV,
        DONE
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake plus the SPI pins of spi_master.
// The master modport is the DUT side; slave is the side that drives commands and MISO.
interface spi_master_if;
    import spi_master_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [MEM_WIDTH-1:0] cmd_byte;
    logic                 rsp_valid;
    logic [MEM_WIDTH-1:0] rsp_data;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic                 busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_byte, MISO,
        output cmd_ready, rsp_valid, rsp_data, SS_n, MOSI, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_byte, MISO,
        input  cmd_ready, rsp_valid, rsp_data, SS_n, MOSI, busy
    );

endinterface

// File: rtl/spi_master_shreg.sv
// Loadable frame shift register: MSB shifts out toward MOSI while the serial
// input fills from the LSB, so the same register transmits and receives.
module spi_master_shreg
    import spi_master_pkg::*;
(
    input  logic               clk,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    input  logic               shift,
    input  logic               sin,
    output logic [FRAME_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[FRAME_W-2:0], sin};
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI command master: sends a 10-bit {opcode, byte} frame MSB first and, for
// RD_DATA, waits RD_WAIT cycles then shifts a byte in from MISO.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int RD_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    spi_state_e         state;
    spi_op_e            op_q;
    logic [3:0]         bit_cnt;
    logic [3:0]         wait_cnt;
    logic [FRAME_W-1:0] sr_q;
    logic               accept;
    logic               sr_shift;
    logic               sr_sin;

    assign accept = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;

    // CHK_CMD already drives frame[9], so the register starts shifting there to
    // keep its MSB one bit ahead of the registered MOSI.
    assign sr_shift = (state == CHK_CMD) || (state == SEND) || (state == RECV);
    assign sr_sin   = (state == RECV) ? bus.MISO : 1'b0;

    spi_master_shreg u_shreg (
        .clk      (clk),
        .load     (accept),
        .load_val ({bus.cmd_op, bus.cmd_byte}),
        .shift    (sr_shift),
        .sin      (sr_sin),
        .q        (sr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= WR_ADDR;
            bit_cnt       <= '0;
            wait_cnt      <= '0;
            bus.SS_n      <= 1'b1;
            bus.MOSI      <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= CHK_CMD;
                        op_q          <= spi_op_e'(bus.cmd_op);
                        bus.SS_n      <= 1'b0;
                        bus.MOSI      <= bus.cmd_op[1];
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                CHK_CMD: begin
                    state    <= SEND;
                    bus.MOSI <= sr_q[FRAME_W-1];
                    bit_cnt  <= '0;
                end
                SEND: begin
                    if (bit_cnt == 4'(FRAME_W - 1)) begin
                        bus.MOSI <= 1'b0;
                        bit_cnt  <= '0;
                        if (op_q == RD_DATA) begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end else begin
                            state    <= DONE;
                            bus.SS_n <= 1'b1;
                        end
                    end else begin
                        bus.MOSI <= sr_q[FRAME_W-1];
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(RD_WAIT - 1)) begin
                        state    <= RECV;
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RECV: begin
                    // The last MISO bit is taken straight from the pin so the
                    // byte is complete on the edge that enters DONE.
                    if (bit_cnt == 4'(MEM_WIDTH - 1)) begin
                        state         <= DONE;
                        bit_cnt       <= '0;
                        bus.SS_n      <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= {sr_q[MEM_WIDTH-2:0], bus.MISO};
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (RD_WAIT=2 and RD_WAIT=1)
// checked cycle by cycle against a frame-level model of the SPI protocol.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_if ifa ();
    spi_master_if ifb ();

    spi_master #(.RD_WAIT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    spi_master #(.RD_WAIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    logic [1:0] cv;
    logic [1:0] opv [2];
    logic [7:0] bv  [2];
    logic [1:0] mi;

    assign ifa.cmd_valid = cv[0];
    assign ifa.cmd_op    = opv[0];
    assign ifa.cmd_byte  = bv[0];
    assign ifa.MISO      = mi[0];
    assign ifb.cmd_valid = cv[1];
    assign ifb.cmd_op    = opv[1];
    assign ifb.cmd_byte  = bv[1];
    assign ifb.MISO      = mi[1];

    logic [1:0] ss, mo, rdy, bsy, rv;
    logic [7:0] rd [2];
    assign ss  = {ifb.SS_n, ifa.SS_n};
    assign mo  = {ifb.MOSI, ifa.MOSI};
    assign rdy = {ifb.cmd_ready, ifa.cmd_ready};
    assign bsy = {ifb.busy, ifa.busy};
    assign rv  = {ifb.rsp_valid, ifa.rsp_valid};
    assign rd[0] = ifa.rsp_data;
    assign rd[1] = ifb.rsp_data;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_data [2];

    // Waits (bounded) for the edge that accepts the command on instance d.
    // Returns with the caller placed 1ns into cycle A+1.
    task automatic wait_accept(input int d, input string tag, output bit ok);
        logic r;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            r = rdy[d];
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) $display("FAIL %s accept: cmd_ready never seen high within 50 cycles", tag);
        else passed++;
    endtask

    // One full command on instance d, every cycle compared against the model.
    task automatic run_frame(input int d, input logic [1:0] op, input logic [7:0] b,
                             input logic [7:0] mb, input bit noise, input string tag);
        int rw, len, rs, e_mo_i;
        bit rdcmd, ok;
        logic [9:0] frame;
        logic e_ss, e_mo, e_rv, e_rdy, e_bsy;
        rw    = (d == 0) ? 2 : 1;
        rdcmd = (op == 2'b11);
        len   = rdcmd ? 19 + rw : 11;
        rs    = 12 + rw;
        frame = {op, b};
        cv[d] = 1'b1; opv[d] = op; bv[d] = b;
        wait_accept(d, tag, ok);
        cv[d] = 1'b0;
        if (!ok) return;
        for (int k = 1; k <= len + 2; k++) begin
            if (noise) begin
                cv[d]  = (k == len + 2) ? 1'b0 : ((k == len + 1) ? 1'b1 : 1'($urandom));
                opv[d] = 2'($urandom);
                bv[d]  = 8'($urandom);
            end
            if (rdcmd && k >= rs && k < rs + 8) mi[d] = mb[7 - (k - rs)];
            else mi[d] = 1'($urandom);
            e_ss  = (k <= len) ? 1'b0 : 1'b1;
            e_mo_i = 11 - k;
            e_mo  = (k == 1) ? op[1] : ((k <= 11) ? frame[e_mo_i] : 1'b0);
            e_rv  = rdcmd && (k == len + 1);
            e_rdy = (k == len + 2);
            e_bsy = (k <= len + 1);
            if (e_rv) exp_data[d] = mb;
            total++;
            if (ss[d] !== e_ss) $display("FAIL %s SS_n k=%0d got %b exp %b", tag, k, ss[d], e_ss);
            else passed++;
            total++;
            if (mo[d] !== e_mo) $display("FAIL %s MOSI k=%0d got %b exp %b", tag, k, mo[d], e_mo);
            else passed++;
            total++;
            if (rv[d] !== e_rv) $display("FAIL %s rsp_valid k=%0d got %b exp %b", tag, k, rv[d], e_rv);
            else passed++;
            total++;
            if (rdy[d] !== e_rdy) $display("FAIL %s cmd_ready k=%0d got %b exp %b", tag, k, rdy[d], e_rdy);
            else passed++;
            total++;
            if (bsy[d] !== e_bsy) $display("FAIL %s busy k=%0d got %b exp %b", tag, k, bsy[d], e_bsy);
            else passed++;
            total++;
            if (rd[d] !== exp_data[d]) $display("FAIL %s rsp_data k=%0d got %h exp %h", tag, k, rd[d], exp_data[d]);
            else passed++;
            @(posedge clk); #1;
        end
        if (noise) begin
            total++;
            if (ss[d] !== 1'b1) $display("FAIL %s noise_not_queued: SS_n got %b exp 1", tag, ss[d]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        cv = '0; mi = '0;
        for (int d = 0; d < 2; d++) begin
            opv[d] = '0; bv[d] = '0; exp_data[d] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({ss[d], mo[d], rdy[d], bsy[d], rv[d]} !== 5'b10000)
                $display("FAIL reset_outputs d=%0d got ss/mosi/rdy/busy/rv=%b exp 10000", d,
                         {ss[d], mo[d], rdy[d], bsy[d], rv[d]});
            else passed++;
            total++;
            if (rd[d] !== 8'h00) $display("FAIL reset_rsp_data d=%0d got %h exp 00", d, rd[d]);
            else passed++;
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy !== 2'b00) $display("FAIL ready_before_edge got %b exp 00", rdy);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (rdy !== 2'b11) $display("FAIL ready_first_edge got %b exp 11", rdy);
        else passed++;
    endtask

    task automatic test_wr_addr();
        run_frame(0, 2'b00, 8'hA5, 8'h00, 1'b0, "wr_addr_a5");
    endtask

    task automatic test_read_sequence();
        run_frame(0, 2'b01, 8'h3C, 8'h00, 1'b0, "wr_data_3c");
        run_frame(0, 2'b10, 8'h3C, 8'h00, 1'b0, "rd_addr_3c");
        run_frame(0, 2'b11, 8'h00, 8'h3C, 1'b0, "rd_data_3c");
    endtask

    task automatic test_rd_wait1();
        run_frame(1, 2'b11, 8'h5A, 8'h81, 1'b0, "rd_wait1_81");
    endtask

    task automatic test_ignore_during_send();
        run_frame(0, 2'b01, 8'hC3, 8'h00, 1'b1, "noise_wr");
        run_frame(1, 2'b11, 8'h0F, 8'hE7, 1'b1, "noise_rd");
    endtask

    task automatic test_random();
        int d;
        logic [1:0] op;
        for (int i = 0; i < 12; i++) begin
            d  = int'($urandom_range(0, 1));
            op = 2'($urandom);
            run_frame(d, op, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] frames [4];
        logic [9:0] f;
        int i, j, e_i;
        bit ok;
        logic e_ss, e_mo;
        for (int n = 0; n < 4; n++) frames[n] = {1'b0, 1'(n % 2), 8'($urandom)};
        cv[0] = 1'b1; opv[0] = frames[0][9:8]; bv[0] = frames[0][7:0];
        wait_accept(0, "b2b", ok);
        if (!ok) begin
            cv[0] = 1'b0;
            return;
        end
        for (int k = 1; k <= 52; k++) begin
            i = (k - 1) / 13;
            j = (k - 1) % 13 + 1;
            if (j == 1) begin
                if (i < 3) begin
                    opv[0] = frames[i + 1][9:8];
                    bv[0]  = frames[i + 1][7:0];
                end else begin
                    cv[0] = 1'b0;
                end
            end
            f    = frames[i];
            e_i  = 11 - j;
            e_ss = (j <= 11) ? 1'b0 : 1'b1;
            e_mo = (j == 1) ? f[9] : ((j <= 11) ? f[e_i] : 1'b0);
            total++;
            if (ss[0] !== e_ss) $display("FAIL b2b SS_n frame=%0d j=%0d got %b exp %b", i, j, ss[0], e_ss);
            else passed++;
            total++;
            if (mo[0] !== e_mo) $display("FAIL b2b MOSI frame=%0d j=%0d got %b exp %b", i, j, mo[0], e_mo);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if (ss[0] !== 1'b1) $display("FAIL b2b no_extra_frame: SS_n got %b exp 1", ss[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        cv[0] = 1'b1; opv[0] = 2'b11; bv[0] = 8'h77;
        wait_accept(0, "mid_reset", ok);
        cv[0] = 1'b0;
        if (!ok) return;
        repeat (5) begin
            mi[0] = 1'($urandom);
            @(posedge clk); #1;
        end
        total++;
        if (ss[0] !== 1'b0) $display("FAIL mid_reset in_frame: SS_n got %b exp 0", ss[0]);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        exp_data[0] = 8'h00; exp_data[1] = 8'h00;
        total++;
        if ({ss[0], mo[0], bsy[0], rv[0], rdy[0]} !== 5'b10000)
            $display("FAIL mid_reset async: ss/mosi/busy/rv/rdy got %b exp 10000",
                     {ss[0], mo[0], bsy[0], rv[0], rdy[0]});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy[0] !== 1'b0) $display("FAIL mid_reset ready_early got %b exp 0", rdy[0]);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (rdy[0] !== 1'b1) $display("FAIL mid_reset ready_after got %b exp 1", rdy[0]);
        else passed++;
        for (int k = 0; k < 25; k++) begin
            mi[0] = 1'($urandom);
            total++;
            if ({ss[0], rv[0]} !== 2'b10 || rd[0] !== 8'h00)
                $display("FAIL mid_reset aborted k=%0d ss/rv got %b exp 10 rsp_data %h exp 00",
                         k, {ss[0], rv[0]}, rd[0]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_wr_addr();
        test_read_sequence();
        test_rd_wait1();
        test_ignore_during_send();
        test_back_to_back();
        test_random();
        test_reset_mid_send();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter RD_WAIT, default 2: SS_n-low idle cycles between the last command bit and the first MISO data bit of a RD_DATA frame (range 1..15).
REQ-002 clk  input  1  system clock; also the SPI bit clock shared with the slave.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high when a command can be accepted.
REQ-006 cmd_op  input  2  opcode: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
REQ-007 cmd_byte  input  8  address or write data.
REQ-008 rsp_valid  output  1  one-cycle pulse: rsp_data holds read byte.
REQ-009 rsp_data  output  8  byte received on MISO.
REQ-010 SS_n  output  1  slave select, active-low.
REQ-011 MOSI  output  1  serial data to slave, MSB first.
REQ-012 MISO  input  1  serial data from slave, MSB first.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, CHK_CMD, SEND, WAIT, RECV, DONE; all outputs registered.
REQ-015 Accept on posedge with cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE.
REQ-016 At acceptance, capture frame = {cmd_op, cmd_byte} (10 bits); later input changes ignored until the next acceptance.
REQ-017 Cycle A+1 (A = acceptance edge): state CHK_CMD, SS_n=0, MOSI=cmd_op[1] (0 write, 1 read).
REQ-018 Cycles A+2..A+11: state SEND, SS_n=0, MOSI = frame[9] down to frame[0], one bit per cycle; a 4-bit counter counts 10 bits.
REQ-019 After SEND, opcodes 00/01/10 go to DONE at A+12: SS_n=1, MOSI=0, no rsp_valid; IDLE (cmd_ready=1) at A+13.
REQ-020 RD_DATA: after SEND, WAIT for RD_WAIT cycles with SS_n=0, MOSI=0.
REQ-021 RECV: 8 cycles with SS_n=0; MISO sampled on each closing posedge, shifted in MSB first.
REQ-022 RD_DATA DONE at A+20+RD_WAIT: SS_n=1, rsp_valid=1 for exactly one cycle, rsp_data = assembled byte; rsp_data holds until the next RD_DATA DONE.
REQ-023 MOSI = 0 whenever SS_n = 1.
REQ-024 cmd_valid outside IDLE: ignored; not queued.
REQ-025 Back-to-back: a command valid during DONE is not accepted; one accepted at the first IDLE edge yields SS_n high for exactly 2 cycles (DONE, IDLE) between frames.
REQ-026 MISO is ignored outside RECV.

Reset
REQ-027 rst_n low: immediately state=IDLE, SS_n=1, MOSI=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=8'h00, counters=0.
REQ-028 cmd_ready rises on the first posedge after rst_n deasserts.
REQ-029 Reset mid-frame aborts the frame with no rsp_valid; the partial frame is discarded.

Structure
REQ-030 Opcode enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA) and the spi_master state enum belong in shared_pkg; MEM_WIDTH/ADDR_SIZE use the existing package parameters.
REQ-031 One sub-module, spi_master_shreg: a 10-bit loadable shift register, MSB-out, serial-in, used for both SEND and RECV.
REQ-032 FSM and bit/wait counters live in spi_master.

Verification
REQ-033 Reset mid-SEND (rst_n low at A+6) -> SS_n=1 and MOSI=0 without a clock edge; no rsp_valid; cmd_ready=1 at first edge after release.
REQ-034 WR_ADDR, byte 8'hA5 -> MOSI over A+1..A+11 = 0,0,0,1,0,1,0,0,1,0,1; SS_n high at A+12; no rsp_valid.
REQ-035 WR_DATA 8'h3C, then RD_ADDR 8'h3C, then RD_DATA with slave model returning 8'h3C -> rsp_valid single pulse at A+22 (RD_WAIT=2), rsp_data=8'h3C.
REQ-036 cmd_valid held high continuously with alternating WR_ADDR/WR_DATA -> each frame 11 SS_n-low cycles, SS_n high exactly 2 cycles between frames, no command lost or duplicated.
REQ-037 cmd_valid pulsed during SEND with different op/byte -> ignored; transmitted frame matches the captured command.
REQ-038 RD_DATA, RD_WAIT=1, MISO driven 8'h81 -> rsp_data=8'h81 at A+21; MISO toggles outside RECV do not affect rsp_data.
